// File: rtl/rat_mw.sv
// rat_mw: multi-lane register alias table with CDB forwarding and retirement.
// Ports: rename lanes in, registered per-lane source responses out, writeback
// ports, and ROB flush/retire. Optional macro RAT_BYPASS_EN adds T+1 bypass.
module rat_mw #(
  parameter int NREG = 32,
  parameter int XLEN = 32,
  parameter int TAGW = 7,
  parameter int RW   = 2,
  parameter int WBW  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RW-1:0]             rename_rat_valid,
  input  logic [RW*($clog2(NREG)+1)-1:0] rename_rat_rd,
  input  logic [RW*TAGW-1:0]        rename_rat_robid,
  input  logic [RW*$clog2(NREG)-1:0] rename_rat_rs1,
  input  logic [RW*$clog2(NREG)-1:0] rename_rat_rs2,
  output logic [RW-1:0]             rat_out_valid,
  output logic [RW-1:0]             rat_rs1_valid,
  output logic [RW*XLEN-1:0]        rat_rs1_tagval,
  output logic [RW-1:0]             rat_rs2_valid,
  output logic [RW*XLEN-1:0]        rat_rs2_tagval,
  input  logic [WBW-1:0]            wb_valid,
  input  logic [WBW-1:0]            wb_error,
  input  logic [WBW*TAGW-1:0]       wb_robid,
  input  logic [WBW*($clog2(NREG)+1)-1:0] wb_rd,
  input  logic [WBW*XLEN-1:0]       wb_result,
  input  logic                      rob_flush,
  input  logic                      rob_ret_valid,
  input  logic [$clog2(NREG)-1:0]   rob_ret_rd,
  input  logic [TAGW-1:0]           rob_ret_robid,
  input  logic [XLEN-1:0]           rob_ret_result
);
  localparam int RA = $clog2(NREG);

  logic [TAGW-1:0] tag      [NREG];
  logic [XLEN-1:0] spec_val [NREG];
  logic [XLEN-1:0] comm_val [NREG];
  logic [NREG-1:0] vld;
  logic [NREG-1:0] cmt;

  logic            rn_we  [RW];
  logic [RA-1:0]   rn_rd  [RW];
  logic [TAGW-1:0] rn_tag [RW];
  logic [RA-1:0]   rs     [RW][2];

  logic            wb_we  [WBW];
  logic [RA-1:0]   wb_dst [WBW];
  logic [TAGW-1:0] wb_tag [WBW];
  logic [XLEN-1:0] wb_res [WBW];

  for (genvar i = 0; i < RW; i++) begin : g_ln
    assign rn_rd[i]  = rename_rat_rd[i*(RA+1) +: RA];
    assign rn_tag[i] = rename_rat_robid[i*TAGW +: TAGW];
    assign rn_we[i]  = rename_rat_valid[i]
                     & ~rename_rat_rd[i*(RA+1)+RA]
                     & (rn_rd[i] != '0);
    assign rs[i][0]  = rename_rat_rs1[i*RA +: RA];
    assign rs[i][1]  = rename_rat_rs2[i*RA +: RA];
  end

  for (genvar p = 0; p < WBW; p++) begin : g_wb
    assign wb_dst[p] = wb_rd[p*(RA+1) +: RA];
    assign wb_tag[p] = wb_robid[p*TAGW +: TAGW];
    assign wb_res[p] = wb_result[p*XLEN +: XLEN];
    assign wb_we[p]  = wb_valid[p] & ~wb_error[p]
                     & ~wb_rd[p*(RA+1)+RA];
  end

  // Source lookup for cycle T: table, then CDB, then intra-group override.
  logic            sv [RW][2];
  logic [XLEN-1:0] sd [RW][2];

  always_comb begin
    for (int i = 0; i < RW; i++) begin
      for (int s = 0; s < 2; s++) begin
        sv[i][s] = 1'b1;
        sd[i][s] = '0;
        if (rs[i][s] != '0) begin
          if (cmt[rs[i][s]]) begin
            sd[i][s] = comm_val[rs[i][s]];
          end else if (vld[rs[i][s]]) begin
            sd[i][s] = spec_val[rs[i][s]];
          end else begin
            sv[i][s] = 1'b0;
            sd[i][s] = XLEN'(tag[rs[i][s]]);
            for (int p = 0; p < WBW; p++) begin
              if (wb_we[p] && wb_tag[p] == tag[rs[i][s]]) begin
                sv[i][s] = 1'b1;
                sd[i][s] = wb_res[p];
              end
            end
          end
          // Ascending scan: the youngest older producer wins.
          for (int j = 0; j < i; j++) begin
            if (rn_we[j] && rn_rd[j] == rs[i][s]) begin
              sv[i][s] = 1'b0;
              sd[i][s] = XLEN'(rn_tag[j]);
            end
          end
        end
      end
    end
  end

  logic [RW-1:0]   out_v;
  logic            r1v [RW];
  logic            r2v [RW];
  logic [XLEN-1:0] r1d [RW];
  logic [XLEN-1:0] r2d [RW];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v <= '0;
      for (int i = 0; i < RW; i++) begin
        r1v[i] <= 1'b0;
        r2v[i] <= 1'b0;
        r1d[i] <= '0;
        r2d[i] <= '0;
      end
    end else begin
      out_v <= rename_rat_valid & {RW{~rob_flush}};
      for (int i = 0; i < RW; i++) begin
        r1v[i] <= sv[i][0];
        r2v[i] <= sv[i][1];
        r1d[i] <= sd[i][0];
        r2d[i] <= sd[i][1];
      end
    end
  end

  // Status bits; statement order gives rename > writeback > retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '1;
      cmt <= '1;
      for (int r = 0; r < NREG; r++) comm_val[r] <= '0;
    end else begin
      if (rob_ret_valid && rob_ret_rd != '0) begin
        comm_val[rob_ret_rd] <= rob_ret_result;
        if (tag[rob_ret_rd] == rob_ret_robid)
          cmt[rob_ret_rd] <= 1'b1;
      end
      for (int p = 0; p < WBW; p++) begin
        if (wb_we[p] && tag[wb_dst[p]] == wb_tag[p])
          vld[wb_dst[p]] <= 1'b1;
      end
      if (rob_flush) begin
        vld <= '1;
        cmt <= '1;
      end else begin
        for (int i = 0; i < RW; i++) begin
          if (rn_we[i]) begin
            vld[rn_rd[i]] <= 1'b0;
            cmt[rn_rd[i]] <= 1'b0;
          end
        end
      end
    end
  end

  // Tags and speculative values need no reset.
  always_ff @(posedge clk) begin
    for (int p = 0; p < WBW; p++) begin
      if (wb_we[p] && tag[wb_dst[p]] == wb_tag[p])
        spec_val[wb_dst[p]] <= wb_res[p];
    end
    for (int i = 0; i < RW; i++) begin
      if (rn_we[i] && !rob_flush)
        tag[rn_rd[i]] <= rn_tag[i];
    end
  end

  always_comb begin
    rat_out_valid = out_v;
    for (int i = 0; i < RW; i++) begin
      rat_rs1_valid[i]              = r1v[i];
      rat_rs2_valid[i]              = r2v[i];
      rat_rs1_tagval[i*XLEN +: XLEN] = r1d[i];
      rat_rs2_tagval[i*XLEN +: XLEN] = r2d[i];
`ifdef RAT_BYPASS_EN
      for (int p = 0; p < WBW; p++) begin
        if (!r1v[i] && wb_we[p] && wb_tag[p] == r1d[i][TAGW-1:0]) begin
          rat_rs1_valid[i]              = 1'b1;
          rat_rs1_tagval[i*XLEN +: XLEN] = wb_res[p];
        end
        if (!r2v[i] && wb_we[p] && wb_tag[p] == r2d[i][TAGW-1:0]) begin
          rat_rs2_valid[i]              = 1'b1;
          rat_rs2_tagval[i*XLEN +: XLEN] = wb_res[p];
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_rat_mw.sv
// tb_rat_mw: directed self-checking bench for rat_mw (default build).
// Drives rename/wb/retire/flush steps and checks registered responses.
module tb_rat_mw;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rename_rat_valid;
  logic [11:0] rename_rat_rd;
  logic [13:0] rename_rat_robid;
  logic [9:0]  rename_rat_rs1;
  logic [9:0]  rename_rat_rs2;
  logic [1:0]  rat_out_valid;
  logic [1:0]  rat_rs1_valid;
  logic [63:0] rat_rs1_tagval;
  logic [1:0]  rat_rs2_valid;
  logic [63:0] rat_rs2_tagval;
  logic [1:0]  wb_valid;
  logic [1:0]  wb_error;
  logic [13:0] wb_robid;
  logic [11:0] wb_rd;
  logic [63:0] wb_result;
  logic        rob_flush;
  logic        rob_ret_valid;
  logic [4:0]  rob_ret_rd;
  logic [6:0]  rob_ret_robid;
  logic [31:0] rob_ret_result;

  int vecs = 0;
  int miss = 0;

  rat_mw dut (
    .clk(clk), .rst(rst),
    .rename_rat_valid(rename_rat_valid),
    .rename_rat_rd(rename_rat_rd),
    .rename_rat_robid(rename_rat_robid),
    .rename_rat_rs1(rename_rat_rs1),
    .rename_rat_rs2(rename_rat_rs2),
    .rat_out_valid(rat_out_valid),
    .rat_rs1_valid(rat_rs1_valid),
    .rat_rs1_tagval(rat_rs1_tagval),
    .rat_rs2_valid(rat_rs2_valid),
    .rat_rs2_tagval(rat_rs2_tagval),
    .wb_valid(wb_valid), .wb_error(wb_error),
    .wb_robid(wb_robid), .wb_rd(wb_rd),
    .wb_result(wb_result),
    .rob_flush(rob_flush),
    .rob_ret_valid(rob_ret_valid),
    .rob_ret_rd(rob_ret_rd),
    .rob_ret_robid(rob_ret_robid),
    .rob_ret_result(rob_ret_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [63:0] o,
                     input logic [63:0] e);
    vecs++;
    assert (o === e) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  task automatic idle();
    rename_rat_valid = '0;
    rename_rat_rd    = {6'h20, 6'h20};
    rename_rat_robid = '0;
    rename_rat_rs1   = '0;
    rename_rat_rs2   = '0;
    wb_valid  = '0;
    wb_error  = '0;
    wb_robid  = '0;
    wb_rd     = {6'h20, 6'h20};
    wb_result = '0;
    rob_flush      = 1'b0;
    rob_ret_valid  = 1'b0;
    rob_ret_rd     = '0;
    rob_ret_robid  = '0;
    rob_ret_result = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd0(input logic [4:0] r);
    rename_rat_valid[0] = 1'b1;
    rename_rat_rs1[4:0] = r;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    chk("rst_outv", 64'(rat_out_valid), 64'h0);
    chk("rst_rs1v", 64'(rat_rs1_valid), 64'h0);
    chk("rst_rs1d", rat_rs1_tagval, 64'h0);
    chk("rst_rs2d", rat_rs2_tagval, 64'h0);
    rst = 1'b0;

    // basic read of committed reset value
    rename_rat_valid = 2'b01;
    rename_rat_rs1[4:0] = 5'd5;
    tick(); idle();
    chk("rd5_outv", 64'(rat_out_valid), 64'h1);
    chk("rd5_rs1v", 64'(rat_rs1_valid[0]), 64'h1);
    chk("rd5_rs1d", 64'(rat_rs1_tagval[31:0]), 64'h0);
    chk("rd5_rs2v", 64'(rat_rs2_valid[0]), 64'h1);
    tick();
    chk("outv_pulse", 64'(rat_out_valid), 64'h0);

    // intra-group dependency
    rename_rat_valid = 2'b11;
    rename_rat_rd    = {6'h20, 6'd3};
    rename_rat_robid = {7'h0, 7'h12};
    rename_rat_rs1   = {5'd3, 5'd0};
    rename_rat_rs2   = {5'd4, 5'd0};
    tick(); idle();
    chk("dep_outv", 64'(rat_out_valid), 64'h3);
    chk("dep_l1v", 64'(rat_rs1_valid[1]), 64'h0);
    chk("dep_l1d", 64'(rat_rs1_tagval[63:32]), 64'h12);
    chk("dep_l1s2v", 64'(rat_rs2_valid[1]), 64'h1);
    rd0(5'd3);
    tick(); idle();
    chk("tag3_v", 64'(rat_rs1_valid[0]), 64'h0);
    chk("tag3_d", 64'(rat_rs1_tagval[31:0]), 64'h12);

    // writeback into table, later read
    rename_rat_valid[0] = 1'b1;
    rename_rat_rd[5:0] = 6'd4;
    rename_rat_robid[6:0] = 7'h20;
    tick(); idle();
    tick();
    wb_valid[0] = 1'b1;
    wb_robid[6:0] = 7'h20;
    wb_rd[5:0] = 6'd4;
    wb_result[31:0] = 32'hDEADBEEF;
    tick(); idle();
    rd0(5'd4);
    tick(); idle();
    chk("wb4_v", 64'(rat_rs1_valid[0]), 64'h1);
    chk("wb4_d", 64'(rat_rs1_tagval[31:0]), 64'hDEADBEEF);

    // cycle-T forwarding from wb port 1
    rename_rat_valid[0] = 1'b1;
    rename_rat_rd[5:0] = 6'd4;
    rename_rat_robid[6:0] = 7'h21;
    tick(); idle();
    wb_valid[1] = 1'b1;
    wb_robid[13:7] = 7'h21;
    wb_rd[11:6] = 6'd4;
    wb_result[63:32] = 32'h55;
    rd0(5'd4);
    tick(); idle();
    chk("fwd_v", 64'(rat_rs1_valid[0]), 64'h1);
    chk("fwd_d", 64'(rat_rs1_tagval[31:0]), 64'h55);

    // retire, flush, committed read
    rob_ret_valid = 1'b1;
    rob_ret_rd = 5'd4;
    rob_ret_robid = 7'h21;
    rob_ret_result = 32'h55;
    tick(); idle();
    rob_flush = 1'b1;
    rd0(5'd4);
    tick(); idle();
    chk("flush_outv", 64'(rat_out_valid), 64'h0);
    rd0(5'd4);
    tick(); idle();
    chk("cmt4_outv", 64'(rat_out_valid), 64'h1);
    chk("cmt4_v", 64'(rat_rs1_valid[0]), 64'h1);
    chk("cmt4_d", 64'(rat_rs1_tagval[31:0]), 64'h55);

    // same rd in both lanes: lane 1 wins
    rename_rat_valid = 2'b11;
    rename_rat_rd    = {6'd7, 6'd7};
    rename_rat_robid = {7'h31, 7'h30};
    tick(); idle();
    wb_valid[0] = 1'b1;
    wb_robid[6:0] = 7'h30;
    wb_rd[5:0] = 6'd7;
    wb_result[31:0] = 32'hBAD;
    tick(); idle();
    rd0(5'd7);
    tick(); idle();
    chk("r7_stale_v", 64'(rat_rs1_valid[0]), 64'h0);
    chk("r7_stale_d", 64'(rat_rs1_tagval[31:0]), 64'h31);
    wb_valid[0] = 1'b1;
    wb_robid[6:0] = 7'h31;
    wb_rd[5:0] = 6'd7;
    wb_result[31:0] = 32'd9;
    tick(); idle();
    rd0(5'd7);
    tick(); idle();
    chk("r7_v", 64'(rat_rs1_valid[0]), 64'h1);
    chk("r7_d", 64'(rat_rs1_tagval[31:0]), 64'd9);

    // errored writeback: no forward, no write
    rename_rat_valid[0] = 1'b1;
    rename_rat_rd[5:0] = 6'd8;
    rename_rat_robid[6:0] = 7'h40;
    tick(); idle();
    wb_valid[0] = 1'b1;
    wb_error[0] = 1'b1;
    wb_robid[6:0] = 7'h40;
    wb_rd[5:0] = 6'd8;
    wb_result[31:0] = 32'h77;
    rd0(5'd8);
    tick(); idle();
    chk("err_fwd_v", 64'(rat_rs1_valid[0]), 64'h0);
    chk("err_fwd_d", 64'(rat_rs1_tagval[31:0]), 64'h40);
    rd0(5'd8);
    tick(); idle();
    chk("err_tab_v", 64'(rat_rs1_valid[0]), 64'h0);

    // rename beats retire status; comm_val still written
    rename_rat_valid[0] = 1'b1;
    rename_rat_rd[5:0] = 6'd9;
    rename_rat_robid[6:0] = 7'h50;
    tick(); idle();
    rename_rat_valid[0] = 1'b1;
    rename_rat_rd[5:0] = 6'd9;
    rename_rat_robid[6:0] = 7'h51;
    rob_ret_valid = 1'b1;
    rob_ret_rd = 5'd9;
    rob_ret_robid = 7'h50;
    rob_ret_result = 32'h99;
    tick(); idle();
    rd0(5'd9);
    tick(); idle();
    chk("pri_v", 64'(rat_rs1_valid[0]), 64'h0);
    chk("pri_d", 64'(rat_rs1_tagval[31:0]), 64'h51);
    // flush also suppresses a same-cycle rename of r10
    rob_flush = 1'b1;
    rename_rat_valid[0] = 1'b1;
    rename_rat_rd[5:0] = 6'd10;
    rename_rat_robid[6:0] = 7'h60;
    tick(); idle();
    rename_rat_valid = 2'b11;
    rename_rat_rs1 = {5'd10, 5'd9};
    tick(); idle();
    chk("fl9_v", 64'(rat_rs1_valid[0]), 64'h1);
    chk("fl9_d", 64'(rat_rs1_tagval[31:0]), 64'h99);
    chk("fl10_v", 64'(rat_rs1_valid[1]), 64'h1);
    chk("fl10_d", 64'(rat_rs1_tagval[63:32]), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
